// File: rtl/trivium_seq.sv
// trivium_seq: sequencer between the host byte bus, a Trivium keystream core
// and an output byte FIFO.
//
// Flow: collect KEY_BYTES key bytes and KEY_BYTES IV bytes, pulse core_load,
// clock the core WARMUP_CYCLES times with the output discarded, then clock it
// one bit per cycle. Bits are packed MSB-first into bytes, and each byte is
// written to the FIFO. The core is held whenever a finished byte is waiting
// on a full FIFO, so no keystream bit is lost.
//
// Optional build macro: TRIV_STREAM_LIMIT_EN. When it is defined, the block
// stops in DONE after STREAM_LEN bytes have been written. When it is not
// defined, RUN continues indefinitely.
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous reset, active low
//   data        host byte (key or IV)
//   strob_key   data is a key byte (one cycle)
//   strob_data  data is an IV byte (one cycle)
//   fifo_cnd    FIFO status {full, empty}
//   core_z      core keystream bit, valid whenever core_en=1
//   core_key    assembled key; the first byte received ends up in the MSBs
//   core_iv     assembled IV; same packing as the key
//   core_load   one-cycle load pulse to the core
//   core_en     core step enable
//   stream      keystream byte to the FIFO din
//   wt_sgn      FIFO write strobe
//   sign_reg    status {0, done, err, stall, run, warmup, iv_ok, key_ok}
module trivium_seq #(
  parameter int KEY_BYTES     = 10,
  parameter int WARMUP_CYCLES = 1152,
  parameter int STREAM_LEN    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data,
  input  logic                   strob_key,
  input  logic                   strob_data,
  input  logic [1:0]             fifo_cnd,
  input  logic                   core_z,
  output logic [8*KEY_BYTES-1:0] core_key,
  output logic [8*KEY_BYTES-1:0] core_iv,
  output logic                   core_load,
  output logic                   core_en,
  output logic [7:0]             stream,
  output logic                   wt_sgn,
  output logic [7:0]             sign_reg
);

  localparam int KW = 8 * KEY_BYTES;
  localparam int CW = $clog2(KEY_BYTES + 1);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam logic [CW-1:0] KB_LAST = CW'(KEY_BYTES);
  localparam logic [WW-1:0] WU_LAST = WW'(WARMUP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_COLLECT,
    S_LOAD,
    S_WARMUP,
    S_RUN
`ifdef TRIV_STREAM_LIMIT_EN
    , S_DONE
`endif
  } state_e;

  state_e         state_q, state_d;
  logic [KW-1:0]  key_q, key_d, iv_q, iv_d;
  logic [CW-1:0]  key_cnt_q, key_cnt_d, iv_cnt_q, iv_cnt_d;
  logic [WW-1:0]  warm_q, warm_d;
  logic [6:0]     sbuf_q, sbuf_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     stream_q, stream_d;
  logic           bvld_q, bvld_d;
  logic [7:0]     sign_q, sign_d;
  logic           key_full, iv_full, full, err, run_st, done_st, rekey;

`ifdef TRIV_STREAM_LIMIT_EN
  localparam logic [15:0] SL_LAST = 16'(STREAM_LEN - 1);
  logic [15:0]    bcnt_q, bcnt_d;
`endif

  // fifo_cnd[0] (empty) carries no information for a writer.
  logic unused_sig;
`ifdef TRIV_STREAM_LIMIT_EN
  assign unused_sig = fifo_cnd[0];
`else
  assign unused_sig = fifo_cnd[0] | (STREAM_LEN == 0);
`endif

  assign full     = fifo_cnd[1];
  assign key_full = (key_cnt_q == KB_LAST);
  assign iv_full  = (iv_cnt_q == KB_LAST);
  assign run_st   = (state_q == S_RUN);
`ifdef TRIV_STREAM_LIMIT_EN
  assign done_st  = (state_q == S_DONE);
`else
  assign done_st  = 1'b0;
`endif
  // A key strobe after the stream has started restarts collection.
  assign rekey    = strob_key & (run_st | done_st);

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    iv_d      = iv_q;
    key_cnt_d = key_cnt_q;
    iv_cnt_d  = iv_cnt_q;
    warm_d    = warm_q;
    sbuf_d    = sbuf_q;
    bit_d     = bit_q;
    stream_d  = stream_q;
    bvld_d    = bvld_q;
`ifdef TRIV_STREAM_LIMIT_EN
    bcnt_d    = bcnt_q;
`endif
    core_load = 1'b0;
    core_en   = 1'b0;
    wt_sgn    = 1'b0;
    err       = 1'b0;

    case (state_q)
      S_COLLECT: begin
        if (strob_key && !key_full) begin
          key_d     = {key_q[KW-9:0], data};
          key_cnt_d = key_cnt_q + CW'(1);
        end
        // When both strobes arrive together, the key byte wins.
        if (strob_data && !strob_key && !iv_full) begin
          iv_d     = {iv_q[KW-9:0], data};
          iv_cnt_d = iv_cnt_q + CW'(1);
        end
        err = strob_key & strob_data;
        if (key_full && iv_full) state_d = S_LOAD;
      end
      S_LOAD: begin
        core_load = 1'b1;
        err       = strob_key | strob_data;
        warm_d    = '0;
        state_d   = S_WARMUP;
      end
      S_WARMUP: begin
        core_en = 1'b1;
        err     = strob_key | strob_data;
        if (warm_q == WU_LAST) begin
          state_d = S_RUN;
          bit_d   = 3'd0;
          bvld_d  = 1'b0;
        end else begin
          warm_d = warm_q + WW'(1);
        end
      end
      S_RUN: begin
        core_en = ~(bvld_q & full);
        wt_sgn  = bvld_q & ~full;
        if (wt_sgn) bvld_d = 1'b0;
        if (core_en) begin
          sbuf_d = {sbuf_q[5:0], core_z};
          bit_d  = bit_q + 3'd1;
          // A byte can only complete 8 steps after the previous one, and
          // by then that byte has been written, so setting bvld here never
          // overwrites an unwritten byte.
          if (bit_q == 3'd7) begin
            stream_d = {sbuf_q, core_z};
            bvld_d   = 1'b1;
          end
        end
`ifdef TRIV_STREAM_LIMIT_EN
        if (wt_sgn) begin
          bcnt_d = bcnt_q + 16'd1;
          if (bcnt_q == SL_LAST) state_d = S_DONE;
        end
`endif
      end
`ifdef TRIV_STREAM_LIMIT_EN
      S_DONE: ;
`endif
      default: state_d = S_COLLECT;
    endcase

    if (rekey) begin
      key_d     = {key_q[KW-9:0], data};
      key_cnt_d = CW'(1);
      iv_cnt_d  = '0;
      bit_d     = 3'd0;
      bvld_d    = 1'b0;
      err       = strob_data;
      state_d   = S_COLLECT;
`ifdef TRIV_STREAM_LIMIT_EN
      bcnt_d    = '0;
`endif
    end

    sign_d = {1'b0, done_st, sign_q[5] | err, run_st & bvld_q & full,
              run_st, state_q == S_WARMUP, iv_full, key_full};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_COLLECT;
      key_q     <= '0;
      iv_q      <= '0;
      key_cnt_q <= '0;
      iv_cnt_q  <= '0;
      warm_q    <= '0;
      sbuf_q    <= '0;
      bit_q     <= '0;
      stream_q  <= '0;
      bvld_q    <= 1'b0;
      sign_q    <= '0;
`ifdef TRIV_STREAM_LIMIT_EN
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      key_cnt_q <= key_cnt_d;
      iv_cnt_q  <= iv_cnt_d;
      warm_q    <= warm_d;
      sbuf_q    <= sbuf_d;
      bit_q     <= bit_d;
      stream_q  <= stream_d;
      bvld_q    <= bvld_d;
      sign_q    <= sign_d;
`ifdef TRIV_STREAM_LIMIT_EN
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign core_key = key_q;
  assign core_iv  = iv_q;
  assign stream   = stream_q;
  assign sign_reg = sign_q;

endmodule

// File: tb/tb_trivium_seq.sv
// Bench for trivium_seq. It models the core as a bit source that advances
// only on cycles where core_en is high, skipping the first WARM enabled
// cycles after each load. Each byte the model completes is queued as an
// expected FIFO write and compared when wt_sgn fires.
module tb_trivium_seq;
  localparam int WARM = 1152;
`ifdef TRIV_STREAM_LIMIT_EN
  localparam int SLEN = 4;
`else
  localparam int SLEN = 4096;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  data;
  logic        strob_key, strob_data;
  logic [1:0]  fifo_cnd;
  logic        core_z;
  logic [79:0] core_key, core_iv;
  logic        core_load, core_en, wt_sgn;
  logic [7:0]  stream, sign_reg;

  trivium_seq #(.KEY_BYTES(10), .WARMUP_CYCLES(WARM), .STREAM_LEN(SLEN)) dut (
    .clk(clk), .rst(rst), .data(data), .strob_key(strob_key),
    .strob_data(strob_data), .fifo_cnd(fifo_cnd), .core_z(core_z),
    .core_key(core_key), .core_iv(core_iv), .core_load(core_load),
    .core_en(core_en), .stream(stream), .wt_sgn(wt_sgn), .sign_reg(sign_reg)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [7:0] expq[$];
  logic bits[0:511];
  int gidx = 0, nb = 0, en_cnt = 0;
  logic [7:0] acc = 8'h00;
  bit running = 1'b0;
  int cyc_no = 0, load_cnt = 0, load_cyc = -1, first_wt = -1;
  int en_since_load = 0, en_at_first = -1, wt_cnt = 0, wt_before, wt_base;
  logic [79:0] ld_key, ld_iv;
  logic [7:0]  ld_sign, first_byte, s_sign, s_stream;
  logic [79:0] s_key, s_iv;
  logic        s_en, s_wt, s_load;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample outputs at the negedge, run the core/scoreboard model,
  // then after the rising edge drop strobes and present the next core bit.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    s_key = core_key; s_iv = core_iv; s_sign = sign_reg; s_stream = stream;
    s_en = core_en; s_wt = wt_sgn; s_load = core_load;
    if (core_load === 1'b1) begin
      load_cnt++; load_cyc = cyc_no;
      ld_key = core_key; ld_iv = core_iv; ld_sign = sign_reg;
      running = 1'b1; en_cnt = 0; nb = 0; en_since_load = 0;
    end
    if (wt_sgn === 1'b1) begin
      wt_cnt++;
      if (first_wt < 0) begin
        first_wt = cyc_no; en_at_first = en_since_load; first_byte = stream;
      end
      if (expq.size() == 0) chk("wt_spurious", 80'(wt_sgn), 80'd0);
      else chk("stream", 80'(stream), 80'(expq.pop_front()));
    end
    if (core_en === 1'b1) en_since_load++;
    if (running && core_en === 1'b1) begin
      if (en_cnt < WARM) en_cnt++;
      else begin
        acc = {acc[6:0], core_z};
        gidx++; nb++;
        if (nb == 8) begin expq.push_back(acc); nb = 0; end
      end
    end
    @(posedge clk);
    #1;
    strob_key = 1'b0; strob_data = 1'b0;
    core_z = (running && en_cnt >= WARM) ? bits[gidx] : 1'($urandom);
  endtask

  initial begin
    logic [7:0] pat;
    pat = 8'hB2;
    for (int i = 0; i < 512; i++) bits[i] = (i < 8) ? pat[7-i] : 1'($urandom);
    rst = 1'b0; data = 8'h00; strob_key = 1'b0; strob_data = 1'b0;
    fifo_cnd = 2'b01; core_z = 1'b0;

    // reset
    repeat (3) cyc();
    chk("rst_sign", 80'(s_sign), 80'h0);
    chk("rst_key", s_key, 80'h0);
    chk("rst_iv", s_iv, 80'h0);
    chk("rst_misc", 80'({s_stream, s_en, s_wt, s_load}), 80'h0);
    rst = 1'b1;
    fifo_cnd = 2'b00;

    // collect and load
    for (int i = 0; i < 10; i++) begin data = 8'(i); strob_key = 1'b1; cyc(); end
    for (int i = 0; i < 10; i++) begin data = 8'hF0 + 8'(i); strob_data = 1'b1; cyc(); end
    for (int g = 0; g < 20 && load_cnt < 1; g++) cyc();
    chk("load_cnt1", 80'(load_cnt), 80'd1);
    chk("ld_key", ld_key, 80'h00010203040506070809);
    chk("ld_iv", ld_iv, 80'hF0F1F2F3F4F5F6F7F8F9);
    chk("ld_sign", 80'(ld_sign), 80'h03);

    // warm-up and strobe error
    repeat (10) cyc();
    chk("wu_sign", 80'(s_sign), 80'h07);
    data = 8'hAA; strob_data = 1'b1; cyc();
    cyc();
    chk("wu_err_sign", 80'(s_sign), 80'h27);
    chk("wu_iv_keep", s_iv, 80'hF0F1F2F3F4F5F6F7F8F9);

    // first byte
    for (int g = 0; g < 1300 && first_wt < 0; g++) cyc();
    chk("first_wt_lat", 80'(first_wt - load_cyc), 80'd1161);
    chk("en_before_wt", 80'(en_at_first), 80'd1160);
    chk("first_byte", 80'(first_byte), 80'hB2);
    chk("run_sign", 80'(s_sign), 80'h2B);

    // FIFO full stall
    for (int g = 0; g < 20 && nb != 5; g++) cyc();
    fifo_cnd = 2'b10; wt_before = wt_cnt;
    repeat (20) cyc();
    chk("full_en", 80'(s_en), 80'd0);
    chk("full_wt", 80'(s_wt), 80'd0);
    chk("full_sign", 80'(s_sign), 80'h3B);
    chk("full_nowrite", 80'(wt_cnt), 80'(wt_before));
    fifo_cnd = 2'b00;
    cyc();
    chk("rel_wt", 80'(s_wt), 80'd1);
    chk("rel_en", 80'(s_en), 80'd1);
    chk("rel_count", 80'(wt_cnt), 80'(wt_before + 1));
    chk("rel_q", 80'(expq.size()), 80'd0);

    // re-key mid-byte
    for (int g = 0; g < 20 && nb != 3; g++) cyc();
    running = 1'b0;
    data = 8'hA0; strob_key = 1'b1; cyc();
    chk("rk_q", 80'(expq.size()), 80'd0);
    cyc(); cyc();
    chk("rk_sign", 80'(s_sign), 80'h20);
    chk("rk_en", 80'(s_en), 80'd0);
    for (int i = 1; i < 9; i++) begin data = 8'hA0 + 8'(i); strob_key = 1'b1; cyc(); end
    data = 8'hA9; strob_key = 1'b1; strob_data = 1'b1; cyc();
    cyc(); cyc();
    chk("dbl_sign", 80'(s_sign), 80'h21);
    for (int i = 0; i < 10; i++) begin data = 8'hC0 + 8'(i); strob_data = 1'b1; cyc(); end
    for (int g = 0; g < 20 && load_cnt < 2; g++) cyc();
    chk("load_cnt2", 80'(load_cnt), 80'd2);
    chk("ld2_key", ld_key, 80'hA0A1A2A3A4A5A6A7A8A9);
    chk("ld2_iv", ld_iv, 80'hC0C1C2C3C4C5C6C7C8C9);
    chk("ld2_sign", 80'(ld_sign), 80'h23);

    // stream limit (or its absence)
    wt_base = wt_cnt;
`ifdef TRIV_STREAM_LIMIT_EN
    for (int g = 0; g < 1400 && (wt_cnt - wt_base) < 4; g++) cyc();
    repeat (40) cyc();
    chk("lim_count", 80'(wt_cnt - wt_base), 80'd4);
    chk("lim_sign", 80'(s_sign), 80'h63);
    chk("lim_en", 80'(s_en), 80'd0);
    chk("lim_q", 80'(expq.size()), 80'd0);
`else
    for (int g = 0; g < 1400 && (wt_cnt - wt_base) < 6; g++) cyc();
    chk("nolim_count", 80'(wt_cnt - wt_base), 80'd6);
    chk("nolim_sign", 80'(s_sign), 80'h2B);
    chk("nolim_en", 80'(s_en), 80'd1);
`endif
    chk("load_total", 80'(load_cnt), 80'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
